dmem_store_buffer: RTL and testbench

- Memory-side responder for the processor's dmem port: accepts loads and stores from the pipeline's memory stage and serves them against a slower, handshaked backing SRAM.
- Stores are posted into a DEPTH-entry FIFO and drained in the background.
- Loads are forwarded from the youngest matching buffered store, or fetched from backing memory while the pipeline is stalled.
- Sits between processor dmem outputs and the board data RAM inside the wrapper.

---
 rtl/dmem_store_buffer_if.sv | 35 +++
 rtl/dmem_store_buffer.sv | 187 ++++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_store_buffer_if.sv
// dmem request/response and backing-SRAM bus of the store buffer.
// slave = the buffer itself, master = pipeline plus backing memory.
interface dmem_store_buffer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [31:0]       address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              rden;
  logic [DATA_W-1:0] q_dmem;
  logic              q_valid;
  logic              dmem_stall;
  logic              sb_empty;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  address_dmem, data, wren, rden,
    input  mem_ready, mem_rdata,
    output q_dmem, q_valid, dmem_stall, sb_empty,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output address_dmem, data, wren, rden,
    output mem_ready, mem_rdata,
    input  q_dmem, q_valid, dmem_stall, sb_empty,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO between the dmem port and a handshaked data SRAM.
// Define STORE_FWD_EN to forward loads from buffered stores.
module dmem_store_buffer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic               clock,
  input  logic               reset,
  dmem_store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    READ
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] wdat_q [DEPTH];
  logic              sb_empty_q;
  logic [DATA_W-1:0] q_dmem_q, q_dmem_d;
  logic              q_valid_q, q_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [ADDR_W-1:0] req_addr;
  logic              unused_addr;
  logic              full;
  logic              push;
  logic              pop;
  logic              load;
  logic              load_pend;
  logic              rd_go;
  logic              rd_done;

  assign req_addr    = bus.address_dmem[ADDR_W-1:0];
  assign unused_addr = ^bus.address_dmem[31:ADDR_W];

  assign full    = (count_q == CNT_W'(DEPTH));
  assign push    = bus.wren && !full;
  assign pop     = (state_q == DRAIN) && bus.mem_ready;
  assign rd_done = (state_q == READ) && bus.mem_ready;
  assign load    = bus.rden && !bus.wren;

`ifdef STORE_FWD_EN
  logic              hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q &&
          addr_q[idx] == req_addr) begin
        hit      = load;
        fwd_data = wdat_q[idx];
      end
    end
  end

  assign load_pend = load && !hit;
  assign rd_go     = load_pend;
`else
  // Without comparators a load must wait for a fully drained buffer.
  assign load_pend = load;
  assign rd_go     = load && (count_q == '0);
`endif

  assign bus.dmem_stall = (bus.wren && full) ||
                          (load_pend && !rd_done);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (rd_go) begin
          state_d    = READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr;
        end else if (count_q != '0) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = wdat_q[head_q];
        end
      end
      DRAIN, READ: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    q_dmem_d  = q_dmem_q;
    q_valid_d = 1'b0;
    if (rd_done) begin
      q_dmem_d  = bus.mem_rdata;
      q_valid_d = 1'b1;
    end
`ifdef STORE_FWD_EN
    if (hit) begin
      q_dmem_d  = fwd_data;
      q_valid_d = 1'b1;
    end
`endif
  end

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      sb_empty_q  <= 1'b1;
      q_dmem_q    <= '0;
      q_valid_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        wdat_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      sb_empty_q  <= (count_d == '0);
      q_dmem_q    <= q_dmem_d;
      q_valid_q   <= q_valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (push) begin
        addr_q[tail_q] <= req_addr;
        wdat_q[tail_q] <= bus.data;
      end
    end
  end

  assign bus.q_dmem    = q_dmem_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.sb_empty  = sb_empty_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: directed stores/loads,
// queued expectations checked by a monitor on q_valid and mem handshakes.
module tb_dmem_store_buffer;
  localparam int AW = 12;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mtx_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_store_buffer #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH (4)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  mtx_t          mq[$];
  logic [DW-1:0] lq[$];
  int            total = 0;
  int            bad = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_empty(string nm);
    int n;
    n = 0;
    smp();
    while (!bus.sb_empty && n < 40) begin
      cyc();
      smp();
      n++;
    end
    chk(nm, bus.sb_empty, 1);
  endtask

  mtx_t          me;
  logic [DW-1:0] le;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req && bus.mem_ready) begin
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_unexp: got addr %0h want none",
                   bus.mem_addr);
        end else begin
          me = mq.pop_front();
          chk("mem_we", bus.mem_we, me.we);
          chk("mem_addr", bus.mem_addr, me.addr);
          if (me.we) chk("mem_wdata", bus.mem_wdata, me.wdata);
        end
      end
      if (bus.q_valid) begin
        if (lq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL q_unexp: got %0h want none", bus.q_dmem);
        end else begin
          le = lq.pop_front();
          chk("q_dmem", bus.q_dmem, le);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int st;
  int n;

  initial begin
    bus.address_dmem = '0;
    bus.data         = '0;
    bus.wren         = 1'b0;
    bus.rden         = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = '0;

    // reset state
    cyc();
    cyc();
    smp();
    chk("rst_qv", bus.q_valid, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_empty", bus.sb_empty, 1);
    chk("rst_stall", bus.dmem_stall, 0);
    chk("rst_q", bus.q_dmem, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    smp();
    chk("idle_req", bus.mem_req, 0);
    chk("idle_stall", bus.dmem_stall, 0);

    // single posted store, drained once mem_ready rises
    cyc();
    bus.wren         = 1'b1;
    bus.address_dmem = 32'h010;
    bus.data         = 32'hDEADBEEF;
    mq.push_back('{1'b1, 12'h010, 32'hDEADBEEF});
    smp();
    chk("st_stall", bus.dmem_stall, 0);
    cyc();
    bus.wren = 1'b0;
    smp();
    chk("st_nempty", bus.sb_empty, 0);
    chk("st_noreq", bus.mem_req, 0);
    cyc();
    smp();
    chk("dr_req", bus.mem_req, 1);
    chk("dr_we", bus.mem_we, 1);
    chk("dr_addr", bus.mem_addr, 12'h010);
    cyc();
    bus.mem_ready = 1'b1;
    smp();
    cyc();
    bus.mem_ready = 1'b0;
    smp();
    chk("dr_empty", bus.sb_empty, 1);
    chk("dr_reqoff", bus.mem_req, 0);

    // two stores to 0x020 then a load of 0x020
    cyc();
    bus.wren         = 1'b1;
    bus.address_dmem = 32'h020;
    bus.data         = 32'h1;
    mq.push_back('{1'b1, 12'h020, 32'h1});
    cyc();
    bus.data = 32'h2;
    mq.push_back('{1'b1, 12'h020, 32'h2});
    cyc();
    bus.wren = 1'b0;
    bus.rden = 1'b1;
`ifdef STORE_FWD_EN
    lq.push_back(32'h2);
    smp();
    chk("fwd_stall", bus.dmem_stall, 0);
    cyc();
    bus.rden = 1'b0;
    smp();
    chk("fwd_qv", bus.q_valid, 1);
    cyc();
    smp();
    chk("fwd_qv_pulse", bus.q_valid, 0);
    cyc();
    bus.mem_ready = 1'b1;
    wait_empty("fwd_drain");
    cyc();
    bus.mem_ready = 1'b0;
`else
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    mq.push_back('{1'b0, 12'h020, 32'h0});
    lq.push_back(32'h0BADF00D);
    n = 0;
    smp();
    while (bus.dmem_stall && n < 20) begin
      n++;
      cyc();
      smp();
    end
    chk("nf_stall_cyc", n, 4);
    chk("nf_empty", bus.sb_empty, 1);
    chk("nf_rd_req", bus.mem_req, 1);
    chk("nf_rd_we", bus.mem_we, 0);
    cyc();
    bus.rden      = 1'b0;
    bus.mem_ready = 1'b0;
    smp();
    chk("nf_qv", bus.q_valid, 1);
`endif

    // load miss, memory answers after three wait cycles
    cyc();
    bus.rden         = 1'b1;
    bus.address_dmem = 32'h030;
    bus.mem_rdata    = 32'h12345678;
    mq.push_back('{1'b0, 12'h030, 32'h0});
    lq.push_back(32'h12345678);
    st = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.mem_ready = 1'b1;
      smp();
      if (bus.dmem_stall) st++;
      if (i == 1) begin
        chk("miss_req", bus.mem_req, 1);
        chk("miss_we", bus.mem_we, 0);
        chk("miss_addr", bus.mem_addr, 12'h030);
      end
      cyc();
    end
    bus.rden      = 1'b0;
    bus.mem_ready = 1'b0;
    chk("miss_stall_cyc", st, 4);
    smp();
    chk("miss_qv", bus.q_valid, 1);
    cyc();
    smp();
    chk("miss_qv_pulse", bus.q_valid, 0);
    chk("miss_qhold", bus.q_dmem, 32'h12345678);

    // fill across pointer wrap, fifth store waits for a pop
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.wren         = 1'b1;
      bus.address_dmem = 32'h100 + i;
      bus.data         = 32'hA0 + i;
      mq.push_back('{1'b1, 12'(12'h100 + i), 32'(32'hA0 + i)});
      smp();
      chk("fill_stall", bus.dmem_stall, 0);
    end
    cyc();
    bus.address_dmem = 32'h104;
    bus.data         = 32'hA4;
    mq.push_back('{1'b1, 12'h104, 32'hA4});
    smp();
    chk("full_stall", bus.dmem_stall, 1);
    cyc();
    smp();
    chk("full_stall2", bus.dmem_stall, 1);
    cyc();
    bus.mem_ready = 1'b1;
    smp();
    chk("full_pop_stall", bus.dmem_stall, 1);
    cyc();
    bus.mem_ready = 1'b0;
    smp();
    chk("full_release", bus.dmem_stall, 0);
    cyc();
    bus.wren = 1'b0;
    smp();
    chk("full_nempty", bus.sb_empty, 0);
    cyc();
    bus.mem_ready = 1'b1;
    wait_empty("wrap_drain");
    cyc();
    bus.mem_ready = 1'b0;

    // reset in the middle of a drain discards everything
    cyc();
    bus.wren         = 1'b1;
    bus.address_dmem = 32'h040;
    bus.data         = 32'hAA;
    cyc();
    bus.address_dmem = 32'h044;
    bus.data         = 32'hBB;
    cyc();
    bus.wren = 1'b0;
    cyc();
    smp();
    chk("mid_req", bus.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", bus.mem_req, 0);
    chk("arst_empty", bus.sb_empty, 1);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    smp();
    chk("post_rst_req", bus.mem_req, 0);
    chk("post_rst_empty", bus.sb_empty, 1);

    chk("mq_left", mq.size(), 0);
    chk("lq_left", lq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
